// File: rtl/id_ex_pkg.sv
// Shared encodings and bundle types for the ID/EX issue slot.
// Opcode, function-code and ALU-class constants live here.
package id_ex_pkg;

  localparam logic [2:0] ALU_ADDI   = 3'b000;
  localparam logic [2:0] ALU_SUBI   = 3'b001;
  localparam logic [2:0] ALU_TYPE_R = 3'b010;
  localparam logic [2:0] ALU_ANDI   = 3'b011;
  localparam logic [2:0] ALU_ORI    = 3'b100;
  localparam logic [2:0] ALU_BRFL   = 3'b101;
  localparam logic [2:0] ALU_CMP    = 3'b110;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BRFL  = 6'b010000;
  localparam logic [5:0] OP_CMP   = 6'b010001;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_MUL = 6'b000010;
  localparam logic [5:0] F_DIV = 6'b000001;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic [2:0]  alu_control;
    logic [5:0]  func;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [4:0]  rd;
    logic        reg_write;
  } id_ex_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'd0, v};
  endfunction

  function automatic logic func_legal(input logic [5:0] f);
    logic ok;
    ok = 1'b0;
    case (f)
      F_ADD, F_SUB, F_MUL, F_DIV,
      F_AND, F_OR, F_NOR: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/id_ex_issue_unit_decode.sv
// Combinational instruction decoder: opcode class, function code,
// operands, destination and illegal / multi-cycle flags.
module id_decode
  import id_ex_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic [2:0]  alu_control_o,
  output logic [5:0]  func_o,
  output logic [31:0] data_a_o,
  output logic [31:0] data_b_o,
  output logic [4:0]  rd_o,
  output logic        reg_write_o,
  output logic        illegal_o,
  output logic        is_mul_o,
  output logic        is_div_o
);

  logic [5:0]  opcode;
  logic [5:0]  fcode;
  logic [15:0] imm;
  logic        wr;
  logic        unused_shamt;

  assign opcode       = instr_i[31:26];
  assign fcode        = instr_i[5:0];
  assign imm          = instr_i[15:0];
  assign unused_shamt = ^instr_i[10:6];

  always_comb begin
    alu_control_o = ALU_ADDI;
    func_o        = '0;
    data_a_o      = rs_data_i;
    data_b_o      = '0;
    rd_o          = '0;
    wr            = 1'b0;
    illegal_o     = 1'b0;
    is_mul_o      = 1'b0;
    is_div_o      = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        alu_control_o = ALU_TYPE_R;
        func_o        = fcode;
        data_b_o      = rt_data_i;
        rd_o          = instr_i[15:11];
        wr            = 1'b1;
        illegal_o     = ~func_legal(fcode);
        is_mul_o      = (fcode == F_MUL);
        is_div_o      = (fcode == F_DIV);
      end
      OP_ADDI: begin
        alu_control_o = ALU_ADDI;
        data_b_o      = sext16(imm);
        rd_o          = instr_i[20:16];
        wr            = 1'b1;
      end
      OP_SUBI: begin
        alu_control_o = ALU_SUBI;
        data_b_o      = sext16(imm);
        rd_o          = instr_i[20:16];
        wr            = 1'b1;
      end
      OP_ANDI: begin
        alu_control_o = ALU_ANDI;
        data_b_o      = zext16(imm);
        rd_o          = instr_i[20:16];
        wr            = 1'b1;
      end
      OP_ORI: begin
        alu_control_o = ALU_ORI;
        data_b_o      = zext16(imm);
        rd_o          = instr_i[20:16];
        wr            = 1'b1;
      end
      OP_BRFL: begin
        // b[2:0] carries the flag code for the branch unit
        alu_control_o = ALU_BRFL;
        data_b_o      = zext16(imm);
      end
      OP_CMP: begin
        alu_control_o = ALU_CMP;
        data_b_o      = rt_data_i;
      end
      default: illegal_o = 1'b1;
    endcase
    reg_write_o = wr & (rd_o != 5'd0) & ~illegal_o;
  end

endmodule

// File: rtl/id_ex_issue_unit.sv
// ID/EX issue slot with multi-cycle MUL/DIV hold and flush bubbles.
// Optional illegal-instruction pulse: define ID_ILLEGAL_TRAP_EN.
module id_ex_issue_unit
  import id_ex_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic        ex_busy,
  output logic [2:0]  ex_alu_control,
  output logic [5:0]  ex_func,
  output logic [31:0] ex_data_a,
  output logic [31:0] ex_data_b,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_illegal
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ?
                        MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  id_ex_t         dec_slot;
  logic           dec_illegal;
  logic           dec_is_mul;
  logic           dec_is_div;
  logic           fire;

  id_ex_t         slot_q, slot_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  id_decode u_dec (
    .instr_i       (id_instr),
    .rs_data_i     (id_rs_data),
    .rt_data_i     (id_rt_data),
    .alu_control_o (dec_slot.alu_control),
    .func_o        (dec_slot.func),
    .data_a_o      (dec_slot.data_a),
    .data_b_o      (dec_slot.data_b),
    .rd_o          (dec_slot.rd),
    .reg_write_o   (dec_slot.reg_write),
    .illegal_o     (dec_illegal),
    .is_mul_o      (dec_is_mul),
    .is_div_o      (dec_is_div)
  );

  assign id_ready = (state_q == IDLE) & ~ex_stall;
  assign fire     = id_valid & id_ready;

`ifdef ID_ILLEGAL_TRAP_EN
  logic ill_q, ill_d;
`endif

  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef ID_ILLEGAL_TRAP_EN
    ill_d   = ill_q;
`endif
    if (flush) begin
      valid_d = 1'b0;
      busy_d  = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
`ifdef ID_ILLEGAL_TRAP_EN
      ill_d   = 1'b0;
`endif
    end else if (!ex_stall) begin
      if (state_q == BUSY) begin
        valid_d = 1'b1;
`ifdef ID_ILLEGAL_TRAP_EN
        ill_d   = 1'b0;
`endif
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end else begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
        ill_d   = fire & dec_illegal;
`endif
        if (fire && !dec_illegal) begin
          slot_d  = dec_slot;
          valid_d = 1'b1;
          // count = remaining EX cycles after this one
          if (dec_is_mul && MUL_CYCLES > 1) begin
            state_d = BUSY;
            busy_d  = 1'b1;
            cnt_d   = CW'(MUL_CYCLES - 1);
          end else if (dec_is_div && DIV_CYCLES > 1) begin
            state_d = BUSY;
            busy_d  = 1'b1;
            cnt_d   = CW'(DIV_CYCLES - 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ID_ILLEGAL_TRAP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ill_q <= 1'b0;
    else       ill_q <= ill_d;
  end
  assign ex_illegal = ill_q;
`else
  assign ex_illegal = 1'b0;
`endif

  assign ex_valid       = valid_q;
  assign ex_busy        = busy_q;
  assign ex_alu_control = slot_q.alu_control;
  assign ex_func        = slot_q.func;
  assign ex_data_a      = slot_q.data_a;
  assign ex_data_b      = slot_q.data_b;
  assign ex_rd          = slot_q.rd;
  assign ex_reg_write   = slot_q.reg_write;

endmodule

// File: tb/tb_id_ex_issue_unit.sv
// Self-checking bench for id_ex_issue_unit: directed scenarios plus
// randomized traffic against a cycle-count reference model.
module tb_id_ex_issue_unit;

  localparam int MULC = 4;
  localparam int DIVC = 8;
`ifdef ID_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] id_instr = '0;
  logic [31:0] id_rs_data = '0;
  logic [31:0] id_rt_data = '0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic        ex_stall = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid;
  logic        ex_busy;
  logic [2:0]  ex_alu_control;
  logic [5:0]  ex_func;
  logic [31:0] ex_data_a;
  logic [31:0] ex_data_b;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_illegal;

  int passed = 0;
  int total  = 0;

  id_ex_issue_unit #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clock(clock), .reset(reset),
    .id_instr(id_instr), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_valid(id_valid),
    .id_ready(id_ready), .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_busy(ex_busy),
    .ex_alu_control(ex_alu_control), .ex_func(ex_func),
    .ex_data_a(ex_data_a), .ex_data_b(ex_data_b),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_illegal(ex_illegal)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Spec-level decode: class, operands, and total EX cycles.
  function automatic void ref_decode(
    input  logic [31:0] ins, rs, rt,
    output logic [2:0]  alu,
    output logic [5:0]  fn,
    output logic [31:0] a, b,
    output logic [4:0]  rd,
    output logic        rw, ill,
    output int          n);
    logic [5:0] op;
    op = ins[31:26];
    alu = 3'd0; fn = 6'd0; a = rs; b = 32'd0;
    rd = 5'd0; rw = 1'b0; ill = 1'b0; n = 1;
    case (op)
      6'h00: begin
        alu = 3'd2; fn = ins[5:0]; b = rt; rd = ins[15:11]; rw = 1'b1;
        ill = !(fn inside {6'b100000, 6'b100010, 6'b000010, 6'b000001,
                           6'b100100, 6'b100101, 6'b100111});
        if (fn == 6'd2) n = MULC;
        if (fn == 6'd1) n = DIVC;
      end
      6'h08: begin alu = 3'd0; b = 32'(int'($signed(ins[15:0])));
                   rd = ins[20:16]; rw = 1'b1; end
      6'h09: begin alu = 3'd1; b = 32'(int'($signed(ins[15:0])));
                   rd = ins[20:16]; rw = 1'b1; end
      6'h0C: begin alu = 3'd3; b = 32'(ins[15:0]); rd = ins[20:16];
                   rw = 1'b1; end
      6'h0D: begin alu = 3'd4; b = 32'(ins[15:0]); rd = ins[20:16];
                   rw = 1'b1; end
      6'h10: begin alu = 3'd5; b = 32'(ins[15:0]); end
      6'h11: begin alu = 3'd6; b = rt; end
      default: ill = 1'b1;
    endcase
    if (rd == 5'd0) rw = 1'b0;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    #1;
    tick;
    total++;
    if ({ex_valid, ex_busy, ex_alu_control, ex_func, ex_data_a, ex_data_b,
         ex_rd, ex_reg_write, ex_illegal} !== 83'd0) begin
      $display("FAIL reset_outputs: got v=%b b=%b alu=%b a=%h rd=%0d want all 0",
               ex_valid, ex_busy, ex_alu_control, ex_data_a, ex_rd);
    end else passed++;
    reset = 1'b0;
    tick;
    total++;
    if ({id_ready, ex_valid} !== 2'b10) begin
      $display("FAIL reset_ready: got ready=%b valid=%b want 1 0", id_ready, ex_valid);
    end else passed++;
  endtask

  task automatic test_single_cycle;
    id_instr = 32'h2023FFFC; id_rs_data = 32'd10; id_rt_data = 32'd99;
    id_valid = 1'b1;
    tick;
    total++;
    if ({ex_valid, ex_alu_control, ex_func, ex_data_a, ex_data_b, ex_rd,
         ex_reg_write} !== {1'b1, 3'b000, 6'd0, 32'd10, 32'hFFFFFFFC,
                            5'd3, 1'b1}) begin
      $display("FAIL addi: got v=%b alu=%b a=%h b=%h rd=%0d rw=%b want 1 000 a b=fffffffc rd=3 rw=1",
               ex_valid, ex_alu_control, ex_data_a, ex_data_b, ex_rd, ex_reg_write);
    end else passed++;
    id_instr = 32'h34058000; id_rs_data = 32'h1234;
    tick;
    total++;
    if ({ex_valid, ex_alu_control, ex_data_a, ex_data_b, ex_rd,
         ex_reg_write} !== {1'b1, 3'b100, 32'h1234, 32'h8000, 5'd5, 1'b1}) begin
      $display("FAIL ori: got alu=%b a=%h b=%h rd=%0d rw=%b want 100 1234 8000 5 1",
               ex_alu_control, ex_data_a, ex_data_b, ex_rd, ex_reg_write);
    end else passed++;
    id_instr = 32'h44220000; id_rs_data = 32'd7; id_rt_data = 32'd8;
    tick;
    total++;
    if ({ex_valid, ex_alu_control, ex_data_a, ex_data_b, ex_reg_write} !==
        {1'b1, 3'b110, 32'd7, 32'd8, 1'b0}) begin
      $display("FAIL cmp: got alu=%b a=%h b=%h rw=%b want 110 7 8 0",
               ex_alu_control, ex_data_a, ex_data_b, ex_reg_write);
    end else passed++;
    id_instr = 32'h20200005;
    tick;
    total++;
    if ({ex_valid, ex_rd, ex_reg_write, ex_data_b} !==
        {1'b1, 5'd0, 1'b0, 32'd5}) begin
      $display("FAIL rd_zero: got rd=%0d rw=%b b=%h want 0 0 5",
               ex_rd, ex_reg_write, ex_data_b);
    end else passed++;
    id_valid = 1'b0;
    tick;
    total++;
    if (ex_valid !== 1'b0) begin
      $display("FAIL bubble: got valid=%b want 0", ex_valid);
    end else passed++;
  endtask

  task automatic test_mul_hold;
    int busy_n;
    int rdy_lo;
    busy_n = 0; rdy_lo = 0;
    id_instr = 32'h00222002; id_rs_data = 32'd7; id_rt_data = 32'd9;
    id_valid = 1'b1;
    tick;
    total++;
    if ({ex_valid, ex_busy, ex_alu_control, ex_func, ex_data_a, ex_data_b,
         ex_rd, ex_reg_write} !== {1'b1, 1'b1, 3'b010, 6'b000010, 32'd7,
                                   32'd9, 5'd4, 1'b1}) begin
      $display("FAIL mul_issue: got v=%b b=%b alu=%b f=%b rd=%0d want 1 1 010 000010 4",
               ex_valid, ex_busy, ex_alu_control, ex_func, ex_rd);
    end else passed++;
    id_instr = 32'h2023FFFC;
    for (int c = 1; c <= 4; c++) begin
      if (ex_busy) busy_n++;
      if (!id_ready) rdy_lo++;
      if (c == 4) begin
        total++;
        if ({ex_valid, ex_busy, ex_alu_control} !== {1'b1, 1'b0, 3'b010}) begin
          $display("FAIL mul_last: got v=%b busy=%b alu=%b want 1 0 010",
                   ex_valid, ex_busy, ex_alu_control);
        end else passed++;
      end
      tick;
    end
    total++;
    if ({busy_n[3:0], rdy_lo[3:0]} !== 8'h33) begin
      $display("FAIL mul_counts: got busy=%0d ready_low=%0d want 3 3", busy_n, rdy_lo);
    end else passed++;
    total++;
    if ({ex_valid, ex_alu_control, ex_rd} !== {1'b1, 3'b000, 5'd3}) begin
      $display("FAIL mul_next: got v=%b alu=%b rd=%0d want 1 000 3",
               ex_valid, ex_alu_control, ex_rd);
    end else passed++;
    id_valid = 1'b0;
    tick;
  endtask

  task automatic test_div_flush;
    id_instr = 32'h00222001; id_valid = 1'b1;
    tick;
    id_valid = 1'b0;
    tick;
    tick;
    total++;
    if ({ex_valid, ex_busy, id_ready} !== 3'b110) begin
      $display("FAIL div_busy: got v=%b busy=%b ready=%b want 1 1 0",
               ex_valid, ex_busy, id_ready);
    end else passed++;
    flush = 1'b1; id_valid = 1'b1; id_instr = 32'h2023FFFC;
    tick;
    flush = 1'b0; id_valid = 1'b0;
    total++;
    if ({ex_valid, ex_busy, id_ready} !== 3'b001) begin
      $display("FAIL div_flush: got v=%b busy=%b ready=%b want 0 0 1",
               ex_valid, ex_busy, id_ready);
    end else passed++;
    flush = 1'b1; ex_stall = 1'b1; id_valid = 1'b1;
    tick;
    flush = 1'b0; ex_stall = 1'b0; id_valid = 1'b0;
    total++;
    if (ex_valid !== 1'b0) begin
      $display("FAIL flush_fire: got valid=%b want 0", ex_valid);
    end else passed++;
  endtask

  task automatic test_stall_mul;
    int busy_n;
    busy_n = 0;
    id_instr = 32'h00222002; id_rs_data = 32'd5; id_rt_data = 32'd6;
    id_valid = 1'b1;
    tick;
    id_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (!ex_busy) break;
      busy_n++;
      ex_stall = (c == 2 || c == 3);
      if (ex_stall) begin
        total++;
        if ({id_ready, ex_valid, ex_alu_control, ex_func, ex_data_a,
             ex_data_b, ex_rd, ex_reg_write} !==
            {1'b0, 1'b1, 3'b010, 6'b000010, 32'd5, 32'd6, 5'd4, 1'b1}) begin
          $display("FAIL stall_hold c=%0d: got ready=%b v=%b a=%h b=%h want 0 1 5 6",
                   c, id_ready, ex_valid, ex_data_a, ex_data_b);
        end else passed++;
      end
      tick;
    end
    ex_stall = 1'b0;
    total++;
    if (busy_n != MULC - 1 + 2) begin
      $display("FAIL stall_extend: got busy cycles=%0d want %0d", busy_n, MULC + 1);
    end else passed++;
    tick;
  endtask

  task automatic test_illegal;
    logic [31:0] bad [2];
    bad[0] = 32'h0000003F;
    bad[1] = 32'hFC000000;
    for (int i = 0; i < 2; i++) begin
      id_instr = bad[i]; id_valid = 1'b1;
      tick;
      id_valid = 1'b0;
      total++;
      if ({ex_valid, ex_illegal} !== {1'b0, TRAP}) begin
        $display("FAIL illegal_%0d: got v=%b ill=%b want 0 %b",
                 i, ex_valid, ex_illegal, TRAP);
      end else passed++;
      tick;
      total++;
      if (ex_illegal !== 1'b0) begin
        $display("FAIL illegal_pulse_%0d: got ill=%b want 0", i, ex_illegal);
      end else passed++;
    end
  endtask

  task automatic test_random;
    logic [2:0]  m_alu, d_alu;
    logic [5:0]  m_fn, d_fn;
    logic [31:0] m_a, m_b, d_a, d_b;
    logic [4:0]  m_rd, d_rd;
    logic        m_rw, d_rw, d_ill, m_valid, m_ill, fire, exp_rdy;
    int          m_hold, d_n, k;
    logic [5:0]  fsel [7];
    logic [5:0]  op;
    logic [15:0] lo;
    fsel[0] = 6'b100000; fsel[1] = 6'b100010; fsel[2] = 6'b000010;
    fsel[3] = 6'b000001; fsel[4] = 6'b100100; fsel[5] = 6'b100101;
    fsel[6] = 6'b100111;
    reset = 1'b1;
    #1;
    tick;
    reset = 1'b0;
    m_alu = 0; m_fn = 0; m_a = 0; m_b = 0; m_rd = 0; m_rw = 0;
    m_valid = 0; m_ill = 0; m_hold = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      k = int'($urandom_range(0, 11));
      lo = 16'($urandom);
      case (k)
        0, 1: begin op = 6'h00; lo[5:0] = fsel[$urandom_range(0, 6)]; end
        2: begin op = 6'h00; lo[5:0] = 6'b000010; end
        3: begin op = 6'h00; lo[5:0] = 6'b000001; end
        4: op = 6'h00;
        5: op = 6'h08;
        6: op = 6'h09;
        7: op = 6'h0C;
        8: op = 6'h0D;
        9: op = 6'h10;
        10: op = 6'h11;
        default: op = 6'($urandom);
      endcase
      id_instr   = {op, 5'($urandom), 5'($urandom), lo};
      id_rs_data = $urandom;
      id_rt_data = $urandom;
      id_valid   = ($urandom_range(0, 3) != 0);
      ex_stall   = ($urandom_range(0, 5) == 0);
      flush      = ($urandom_range(0, 11) == 0);
      #1;
      exp_rdy = (m_hold <= 1) && !ex_stall;
      total++;
      if (id_ready !== exp_rdy) begin
        $display("FAIL rnd_ready cyc=%0d: got %b want %b", cyc, id_ready, exp_rdy);
      end else passed++;
      fire = id_valid && exp_rdy;
      ref_decode(id_instr, id_rs_data, id_rt_data,
                 d_alu, d_fn, d_a, d_b, d_rd, d_rw, d_ill, d_n);
      tick;
      if (flush) begin
        m_valid = 0; m_ill = 0; m_hold = 0;
      end else if (!ex_stall) begin
        m_ill = 0;
        if (m_hold > 1) begin
          m_hold--;
        end else if (fire && !d_ill) begin
          m_alu = d_alu; m_fn = d_fn; m_a = d_a; m_b = d_b;
          m_rd = d_rd; m_rw = d_rw; m_valid = 1; m_hold = d_n;
        end else begin
          m_valid = 0; m_hold = 0;
          m_ill = fire && TRAP;
        end
      end
      total++;
      if ({ex_valid, ex_busy, ex_illegal, ex_alu_control, ex_func,
           ex_data_a, ex_data_b, ex_rd, ex_reg_write} !==
          {m_valid, (m_hold > 1), m_ill, m_alu, m_fn, m_a, m_b, m_rd,
           m_rw}) begin
        $display("FAIL rnd_slot cyc=%0d: got v=%b bz=%b il=%b alu=%b f=%b a=%h b=%h rd=%0d rw=%b want v=%b bz=%b il=%b alu=%b f=%b a=%h b=%h rd=%0d rw=%b",
                 cyc, ex_valid, ex_busy, ex_illegal, ex_alu_control, ex_func,
                 ex_data_a, ex_data_b, ex_rd, ex_reg_write, m_valid,
                 (m_hold > 1), m_ill, m_alu, m_fn, m_a, m_b, m_rd, m_rw);
      end else passed++;
    end
    id_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_cycle;
    test_mul_hold;
    test_div_flush;
    test_stall_mul;
    test_illegal;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_issue_unit.md
Name: id_ex_issue_unit

Overview:
- Decode-to-execute issue stage that feeds the EX-stage ALU.
- Accepts a fetched instruction plus register-file read data through a valid/ready handshake.
- Decodes it into ALU opcode class, function code and operands, then holds it in a registered ID/EX slot.
- Holds operands stable for the extra cycles that multi-cycle MUL/DIV need in EX, and inserts bubbles on flush.

Parameters:
- MUL_CYCLES, 4, total EX cycles a MUL occupies (>=1)
- DIV_CYCLES, 8, total EX cycles a DIV occupies (>=1)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_instr  in  32  instruction word
- id_rs_data  in  32  register-file value for instr[25:21]
- id_rt_data  in  32  register-file value for instr[20:16]
- id_valid  in  1  instruction/data valid
- id_ready  out  1  unit can accept this cycle
- ex_stall  in  1  downstream freeze
- flush  in  1  kill the slot (branch taken)
- ex_valid  out  1  slot holds a live instruction
- ex_busy  out  1  slot is in a multi-cycle hold
- ex_alu_control  out  3  ADDI=000 SUBI=001 TYPE_R=010 ANDI=011 ORI=100 BRFL=101 CMP=110
- ex_func  out  6  R-type function code (000000 otherwise)
- ex_data_a  out  32  ALU operand A
- ex_data_b  out  32  ALU operand B
- ex_rd  out  5  destination register
- ex_reg_write  out  1  writeback enable
- ex_illegal  out  1  illegal-instruction pulse (see Optional Feature)

Behaviour:
- Reset (async): all ex_* outputs 0, state IDLE, counter 0.
- id_ready = (state==IDLE) & ~ex_stall.
- Opcode map, instr[31:26]:
  - 000000 → TYPE_R
  - 001000 → ADDI
  - 001001 → SUBI
  - 001100 → ANDI
  - 001101 → ORI
  - 010000 → BRFL
  - 010001 → CMP
  - any other opcode is illegal.
- Legal R-type func values: 100000, 100010, 000010, 000001, 100100, 100101, 100111. Any other func is illegal.
- Operands:
  - TYPE_R/CMP: a = rs_data, b = rt_data.
  - ADDI/SUBI: a = rs_data, b = sign-extended imm[15:0].
  - ANDI/ORI: a = rs_data, b = zero-extended imm[15:0].
  - BRFL: a = rs_data (target), b = zero-extended imm (flag code in b[2:0]).
- Destination: TYPE_R → rd = instr[15:11]; ADDI/SUBI/ANDI/ORI → rd = instr[20:16]. reg_write = 1 for these, 0 for BRFL/CMP.
- rd==0 forces reg_write=0.
- Latency: fire = id_valid & id_ready. The slot loads on the next rising edge; ex_valid=1 from the following cycle.
- No fire and not stalled: slot loads a bubble (ex_valid=0, other fields keep their last value).
- FSM:
  - IDLE→BUSY on fire of MUL (count = MUL_CYCLES-1) or DIV (count = DIV_CYCLES-1), when that count is >0.
  - In BUSY, count decrements each non-stalled cycle; BUSY→IDLE when count reaches 1 at the edge.
  - In BUSY: ex_valid=1, ex_busy=1, all slot fields held, id_ready=0.
  - ex_busy=0 in the final EX cycle.
- ex_stall=1: slot, state and counter all frozen; id_ready=0.
- flush (synchronous): highest priority after reset, overrides ex_stall.
  - Clears ex_valid, ex_busy and ex_illegal; returns to IDLE; zeroes the counter.
  - A simultaneous fire is discarded.
- MUL_CYCLES=1 or DIV_CYCLES=1: no BUSY entry; single-cycle issue.

Optional Feature:
- Macro ID_ILLEGAL_TRAP_EN.
- Defined: an illegal fire loads a bubble (ex_valid=0) and sets ex_illegal=1 for exactly one cycle. It is suppressed by a simultaneous flush and held while ex_stall is high.
- Undefined: an illegal fire loads a bubble silently; ex_illegal is tied 0.

Decomposition:
- Package id_ex_pkg holds:
  - alu_control encodings
  - func codes
  - opcode constants
  - FSM state enum {IDLE, BUSY}
- Sub-module id_decode (purely combinational): instr, rs_data, rt_data → alu_control, func, data_a, data_b, rd, reg_write, illegal, is_mul, is_div.
- Parent owns the slot register, FSM and counter.

Test Plan:
- ADDI 0x2023FFFC, rs_data=10, id_valid=1 → next cycle ex_valid=1, alu_control=000, data_a=10, data_b=0xFFFFFFFC, rd=3, reg_write=1.
- ORI 0x34058000 → data_b=0x00008000, alu_control=100, rd=5; CMP 0x44220000 → reg_write=0, alu_control=110.
- MUL 0x00222002 with MUL_CYCLES=4 and id_valid held → id_ready low 3 cycles; ex_busy high 3 cycles then low 1; next instruction issues on cycle 5.
- DIV (DIV_CYCLES=8) with flush asserted during BUSY count 5 → next cycle ex_valid=0, ex_busy=0, id_ready=1.
- ex_stall held 2 cycles mid-MUL → count and all ex_* outputs unchanged; total busy extended by exactly 2 cycles.
- Illegal R-type 0x0000003F → ex_valid=0; ex_illegal pulses 1 cycle with ID_ILLEGAL_TRAP_EN, stays 0 without.
